// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one single-port synchronous RAM between the CPU and an I/O requester.
// The CPU wins contention unless the I/O port has waited MAX_WAIT cycles; read data returns
// to the issuing port one cycle after the grant.
module mem_arbiter #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned ADDR     = 16,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  // CPU port
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [ADDR-1:0]  cpu_addr,
  input  logic [WIDTH-1:0] cpu_wdata,
  output logic             cpu_gnt,
  output logic             cpu_rvalid,
  output logic [WIDTH-1:0] cpu_rdata,
  // I/O port
  input  logic             io_req,
  input  logic             io_we,
  input  logic [ADDR-1:0]  io_addr,
  input  logic [WIDTH-1:0] io_wdata,
  output logic             io_gnt,
  output logic             io_rvalid,
  output logic [WIDTH-1:0] io_rdata,
  // Memory side
  output logic             mem_en,
  output logic             mem_we,
  output logic [ADDR-1:0]  mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnCpu  = 2'd1,
    OwnIo   = 2'd2
  } own_e;

  logic [3:0] wait_cnt, wait_cnt_d;
  own_e       rd_own, rd_own_d;

  // Grant decision; grants are masked while reset is asserted.
  always_comb begin
    cpu_gnt = 1'b0;
    io_gnt  = 1'b0;
    if (!reset) begin
      if (cpu_req && io_req) begin
        if (wait_cnt >= MaxWait) begin
          io_gnt = 1'b1;
        end else begin
          cpu_gnt = 1'b1;
        end
      end else begin
        cpu_gnt = cpu_req;
        io_gnt  = io_req;
      end
    end
  end

  // Memory request mux; an idle bus drives all zeros.
  always_comb begin
    mem_en    = cpu_gnt | io_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (io_gnt) begin
      mem_we    = io_we;
      mem_addr  = io_addr;
      mem_wdata = io_wdata;
    end
  end

  // Starvation counter: counts consecutive denied I/O cycles, saturating at MaxWait.
  always_comb begin
    wait_cnt_d = wait_cnt;
    if (io_gnt || !io_req) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt < MaxWait) begin
      wait_cnt_d = wait_cnt + 4'd1;
    end
  end

  // Only reads produce return data; writes leave no owner.
  always_comb begin
    rd_own_d = OwnNone;
    if (cpu_gnt && !cpu_we) begin
      rd_own_d = OwnCpu;
    end else if (io_gnt && !io_we) begin
      rd_own_d = OwnIo;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= 4'd0;
      rd_own   <= OwnNone;
    end else begin
      wait_cnt <= wait_cnt_d;
      rd_own   <= rd_own_d;
    end
  end

  always_comb begin
    cpu_rvalid = !reset && (rd_own == OwnCpu);
    io_rvalid  = !reset && (rd_own == OwnIo);
    cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    io_rdata   = io_rvalid  ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small synchronous RAM model on the memory side.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        io_req, io_we, io_gnt, io_rvalid;
  logic [15:0] io_addr, io_wdata, io_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  logic [15:0] ram [256];

  int vectors     = 0;
  int miscompares = 0;

  mem_arbiter #(
    .WIDTH   (16),
    .ADDR    (16),
    .MAX_WAIT(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_gnt   (cpu_gnt),
    .cpu_rvalid(cpu_rvalid),
    .cpu_rdata (cpu_rdata),
    .io_req    (io_req),
    .io_we     (io_we),
    .io_addr   (io_addr),
    .io_wdata  (io_wdata),
    .io_gnt    (io_gnt),
    .io_rvalid (io_rvalid),
    .io_rdata  (io_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Block RAM model, preloaded with 0xBEEF at 0x0010 while reset is high.
  always @(posedge clk) begin
    if (reset) begin
      ram[8'h10] <= 16'hBEEF;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[7:0]];
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    io_req  = 1'b0; io_we  = 1'b0; io_addr  = '0; io_wdata  = '0;

    // Reset: requests present but masked, everything reads zero.
    next_cycle();
    cpu_req = 1'b1; cpu_addr = 16'h0010;
    io_req  = 1'b1; io_addr  = 16'h0011;
    @(negedge clk);
    chk("rst_gnt", {cpu_gnt, io_gnt, mem_en, mem_we}, 4'b0000);
    chk("rst_mem", {mem_addr, mem_wdata}, 32'h0);
    chk("rst_rv", {cpu_rvalid, io_rvalid, cpu_rdata, io_rdata}, 34'h0);
    chk("rst_wait", dut.wait_cnt, 4'd0);
    next_cycle();
    cpu_req = 1'b0; io_req = 1'b0;
    reset = 1'b0;

    // Single CPU read of preloaded 0xBEEF.
    next_cycle();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    @(negedge clk);
    chk("rd_c0_gnt", {cpu_gnt, io_gnt, mem_en, mem_we}, 4'b1010);
    chk("rd_c0_addr", mem_addr, 16'h0010);
    next_cycle();
    cpu_req = 1'b0;
    @(negedge clk);
    chk("rd_c1_rv", {cpu_rvalid, io_rvalid, mem_en}, 3'b100);
    chk("rd_c1_data", {cpu_rdata, io_rdata}, {16'hBEEF, 16'h0000});
    next_cycle();
    @(negedge clk);
    chk("rd_c2_rv", {cpu_rvalid, cpu_rdata}, 17'h0);

    // Contention: C,C,C,C,I repeating, wait_cnt 0..4 then 0.
    next_cycle();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0030;
    io_req  = 1'b1; io_we  = 1'b0; io_addr  = 16'h0040;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("cont%0d_wait", k), dut.wait_cnt, 4'(k % 5));
      chk($sformatf("cont%0d_gnt", k), {cpu_gnt, io_gnt},
          (k % 5 == 4) ? 2'b01 : 2'b10);
      chk($sformatf("cont%0d_addr", k), mem_addr, (k % 5 == 4) ? 16'h0040 : 16'h0030);
      if (k > 0) begin
        chk($sformatf("cont%0d_rv", k), {cpu_rvalid, io_rvalid},
            (k % 5 == 0) ? 2'b01 : 2'b10);
      end
      next_cycle();
    end
    cpu_req = 1'b0; io_req = 1'b0;
    @(negedge clk);
    chk("cont_tail_rv", {cpu_rvalid, io_rvalid, mem_en}, 3'b010);

    // CPU write then I/O read of the same address on the next cycle.
    next_cycle();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 16'h1234;
    @(negedge clk);
    chk("wr_c0", {cpu_gnt, io_gnt, mem_en, mem_we}, 4'b1011);
    chk("wr_c0_bus", {mem_addr, mem_wdata}, {16'h0020, 16'h1234});
    next_cycle();
    cpu_req = 1'b0; cpu_we = 1'b0;
    io_req = 1'b1; io_we = 1'b0; io_addr = 16'h0020;
    @(negedge clk);
    chk("wr_c1", {cpu_gnt, io_gnt, mem_we, cpu_rvalid}, 4'b0100);
    chk("wr_c1_addr", mem_addr, 16'h0020);
    next_cycle();
    io_req = 1'b0;
    @(negedge clk);
    chk("wr_c2_rv", {cpu_rvalid, io_rvalid}, 2'b01);
    chk("wr_c2_data", io_rdata, 16'h1234);

    // Abandoned I/O request under CPU contention.
    next_cycle();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0050;
    io_req  = 1'b1; io_we  = 1'b0; io_addr  = 16'h0060;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("ab%0d", k), {io_gnt, cpu_gnt, dut.wait_cnt}, {2'b01, 4'(k)});
      chk($sformatf("ab%0d_addr", k), mem_addr, 16'h0050);
      next_cycle();
    end
    io_req = 1'b0;
    @(negedge clk);
    chk("ab2", {io_gnt, cpu_gnt, dut.wait_cnt}, {2'b01, 4'd2});
    chk("ab2_addr", mem_addr, 16'h0050);
    next_cycle();
    @(negedge clk);
    chk("ab3_wait", dut.wait_cnt, 4'd0);
    chk("ab3_addr", mem_addr, 16'h0050);
    next_cycle();
    cpu_req = 1'b0;

    // Reset asserted mid-cycle during a granted CPU read, held over the edge.
    next_cycle();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    #1;
    chk("mr_pre", {cpu_gnt, mem_en}, 2'b11);
    reset = 1'b1;
    #1;
    chk("mr_drop", {cpu_gnt, mem_en, mem_addr}, 18'h0);
    next_cycle();
    reset = 1'b0;
    cpu_req = 1'b0;
    @(negedge clk);
    chk("mr_c1_rv", {cpu_rvalid, io_rvalid, cpu_rdata}, 18'h0);
    next_cycle();
    @(negedge clk);
    chk("mr_c2_rv", {cpu_rvalid, io_rvalid, cpu_rdata}, 18'h0);

    // Idle bus for 10 cycles.
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      @(negedge clk);
      chk($sformatf("idle%0d", k),
          {mem_en, mem_we, mem_addr, mem_wdata, cpu_rvalid, io_rvalid, cpu_rdata, io_rdata,
           cpu_gnt, io_gnt},
          70'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single-port synchronous data/instruction memory between the CPU and a secondary I/O requester (display fetch or peripheral DMA). It sits between the CPU's memory interface (`mem_addr`, `writedata`, `memwrite`, `mem_out`) and the block RAM. It issues at most one access per cycle and routes the one-cycle-latency read data back to the issuing port. The CPU has default priority; a saturating wait counter guarantees the I/O port bounded latency.

## Interface
- `WIDTH`, 16, data width
- `ADDR`, 16, address width
- `MAX_WAIT`, 4, consecutive denied I/O cycles before the I/O port is forced to win (1..15)

- `clk`  in  1  system clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high reset
- `cpu_req`  in  1  CPU access request; held with address/data until granted
- `cpu_we`  in  1  1 = write, 0 = read
- `cpu_addr`  in  ADDR  CPU address
- `cpu_wdata`  in  WIDTH  CPU write data
- `cpu_gnt`  out  1  CPU access issued this cycle (combinational)
- `cpu_rvalid`  out  1  `cpu_rdata` valid this cycle (registered)
- `cpu_rdata`  out  WIDTH  read data to CPU
- `io_req`, `io_we`, `io_addr`, `io_wdata`, `io_gnt`, `io_rvalid`, `io_rdata`: same as the CPU set, for the I/O port
- `mem_en`  out  1  memory access enable
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR  memory address
- `mem_wdata`  out  WIDTH  memory write data
- `mem_rdata`  in  WIDTH  memory read data; valid one cycle after a read is issued

## Operation
- Grant decision is combinational each cycle from `cpu_req`, `io_req`, and `wait_cnt`:
  - only one request → grant it
  - both requested, `wait_cnt < MAX_WAIT` → CPU
  - both requested, `wait_cnt == MAX_WAIT` → I/O
  - neither → no grant; `mem_en`=0, `mem_we`=0, `mem_addr`/`mem_wdata`=0
- `cpu_gnt` and `io_gnt` are never both 1. `mem_en` = `cpu_gnt | io_gnt`.
- `mem_we`/`mem_addr`/`mem_wdata` are muxed from the granted port.
- `wait_cnt` (4 bits), updated on the rising edge:
  - clears when `io_gnt`=1 or `io_req`=0
  - otherwise increments, saturating at `MAX_WAIT`
- Read tracking: register `rd_own` (2 bits: none/CPU/I/O) records the owner of a granted read (`we`=0). Writes record none.
  - `cpu_rvalid` = (`rd_own`==CPU); `io_rvalid` = (`rd_own`==I/O).
  - `cpu_rdata` = `mem_rdata` when `cpu_rvalid`, else 0. Same rule for `io_rdata`.
- Requester contract:
  - `req` stays high, with `we`/`addr`/`wdata` stable, until the cycle `gnt`=1.
  - Dropping `req` before grant abandons the request; no access is issued.
  - Back-to-back grants to the same port on consecutive cycles are legal.
- The CPU controller must stall its state machine while `cpu_req`=1 and `cpu_gnt`=0. A granted write completes at that clock edge.

## Timing
- Reset (asynchronous, active-high): `wait_cnt`=0, `rd_own`=none.
  - All outputs are 0 while reset is high: `gnt`, `rvalid`, `rdata`, `mem_*`. Grants are masked during reset.
- Grant latency with no contention: 0 cycles (same cycle as `req`).
- Read data latency: `rvalid` asserts exactly 1 cycle after the granted cycle, for exactly 1 cycle.
- Maximum I/O wait under continuous CPU requests: `MAX_WAIT` denied cycles, then a grant on cycle `MAX_WAIT`+1.
- Maximum CPU wait: 1 cycle per forced I/O grant. After an I/O grant, `wait_cnt`=0, so the CPU wins the next contention.
- Write followed by read to the same address on the next cycle returns the new data; the memory write completes at the first edge.
- Reset asserted with a read in flight: the read is discarded. `rvalid` stays 0 after reset is released, even if `mem_rdata` toggles.
- `MAX_WAIT` outside 1..15 is illegal; behaviour is undefined.

## Test plan
- **Single CPU read:** preload mem[0x0010]=0xBEEF; `cpu_req`=1, `we`=0, addr 0x0010 for 1 cycle.
  - Cycle 0: `cpu_gnt`=1, `mem_en`=1, `mem_addr`=0x0010.
  - Cycle 1: `cpu_rvalid`=1, `cpu_rdata`=0xBEEF, `io_rvalid`=0.
- **Contention with starvation escalation:** `cpu_req` and `io_req` held high continuously, `MAX_WAIT`=4.
  - Grants repeat the pattern C,C,C,C,I, with `wait_cnt` stepping 0→1→2→3→4→0.
- **Interleaved write/read:**
  - Cycle 0: CPU writes 0x1234 to 0x0020.
  - Cycle 1: I/O reads 0x0020.
  - Cycle 2: `io_rvalid`=1, `io_rdata`=0x1234, `cpu_rvalid`=0.
- **Abandoned request:** I/O requests under CPU contention for 2 cycles, then drops `io_req`.
  - No I/O grant is issued, `wait_cnt` returns to 0, and `mem_addr` never shows the I/O address.
- **Reset mid-read:** CPU read granted at cycle 0; `reset` pulses high mid-cycle 0, asynchronously.
  - `cpu_gnt`/`mem_en` drop immediately.
  - `cpu_rvalid`=0 at cycle 1 and stays 0 until a new request.
- **Idle bus:** no requests for 10 cycles.
  - `mem_en`=0, `mem_we`=0, `mem_addr`=0, both `rvalid`=0, both `rdata`=0.
